// File: rtl/dmem_result_checker_if.sv
// Data-memory read port plus expected-value lookup used by dmem_result_checker.
// The master drives read strobe/address and the expected-value index; the slave returns data.
interface dmem_result_checker_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int IW = 5
);
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [IW-1:0] exp_idx;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_mask;

    modport master (
        output rd_en, rd_addr, exp_idx,
        input  rd_data, exp_data, exp_mask
    );

    modport slave (
        input  rd_en, rd_addr, exp_idx,
        output rd_data, exp_data, exp_mask
    );
endinterface

// File: rtl/dmem_result_checker.sv
// Runs the CPU for a bounded time (or until fetch idles), then scans a dmem window
// and compares each word under a bit mask against an expected-value source.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   RUN    | CPU running, counting cycles and idle fetches
//   SCAN   | issuing one read per word, comparing one cycle later
//   DONE   | results held until the next start
module dmem_result_checker #(
    parameter int             DW         = 32,
    parameter int             AW         = 32,
    parameter int             NWORDS     = 32,
    parameter logic [AW-1:0]  BASE_ADDR  = '0,
    parameter int             RUN_CYCLES = 1000,
    parameter int             IDLE_STOP  = 0,
    parameter int             IDLE_LIMIT = 16,
    localparam int            IW         = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int            CW         = $clog2(NWORDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           idata_mon,
    dmem_result_checker_if.master mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  early_stop,
    output logic [CW-1:0]         fail_count,
    output logic [IW-1:0]         first_fail_idx,
    output logic [DW-1:0]         first_fail_got,
    output logic [31:0]           cycle_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int         BYTES  = DW / 8;

    logic [1:0]    state;
    logic [31:0]   idle_cnt;
    logic [IW-1:0] ptr;
    logic          drain;
    logic          cmp_valid;
    logic [IW-1:0] cmp_idx;
    logic          rd_en_i;
    logic          run_last;
    logic          idle_exit;
    logic          mismatch;

    assign rd_en_i   = (state == S_SCAN) && !drain;
    assign run_last  = (cycle_count == 32'(RUN_CYCLES - 1));
    assign idle_exit = (IDLE_STOP != 0) && (idata_mon == 32'd0) &&
                       (idle_cnt == 32'(IDLE_LIMIT - 1));
    assign mismatch  = cmp_valid &&
                       (|((mem.rd_data ^ mem.exp_data) & mem.exp_mask));

    // Address follows the issue pointer, so it simply holds once issuing stops.
    assign mem.rd_en   = rd_en_i;
    assign mem.rd_addr = BASE_ADDR + AW'(ptr) * AW'(BYTES);
    assign mem.exp_idx = cmp_idx;

    assign busy = (state == S_RUN) || (state == S_SCAN);
    assign done = (state == S_DONE);
    assign pass = (state == S_DONE) && (fail_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cycle_count    <= '0;
            idle_cnt       <= '0;
            ptr            <= '0;
            drain          <= 1'b0;
            cmp_valid      <= 1'b0;
            cmp_idx        <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            early_stop     <= 1'b0;
        end else begin
            cmp_valid <= rd_en_i;
            if (rd_en_i) begin
                cmp_idx <= ptr;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        cycle_count    <= '0;
                        idle_cnt       <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_got <= '0;
                        early_stop     <= 1'b0;
                    end
                end
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    idle_cnt    <= (idata_mon == 32'd0) ? idle_cnt + 32'd1 : 32'd0;
                    // Idle exit takes priority so early_stop is set when both fire together.
                    if (idle_exit || run_last) begin
                        state      <= S_SCAN;
                        ptr        <= '0;
                        drain      <= 1'b0;
                        early_stop <= idle_exit;
                    end
                end
                S_SCAN: begin
                    if (!drain) begin
                        if (ptr == IW'(NWORDS - 1)) begin
                            drain <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else begin
                        state <= S_DONE;
                    end
                    if (mismatch) begin
                        fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) begin
                            first_fail_idx <= cmp_idx;
                            first_fail_got <= mem.rd_data;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_result_checker.sv
// Bench for dmem_result_checker: a default instance and a small early-stop instance,
// vector table, corner-case sequences and randomized runs against a reference model.
`timescale 1ns/1ps
module tb_dmem_result_checker;
    localparam int          N0   = 32;
    localparam int          N1   = 8;
    localparam int          RC0  = 1000;
    localparam int          RC1  = 100;
    localparam int          LIM1 = 16;
    localparam logic [31:0] B0   = 32'h0;
    localparam logic [31:0] B1   = 32'h100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] idata0 = 32'h1, idata1 = 32'h1;
    logic        busy0, done0, pass0, es0, busy1, done1, pass1, es1;
    logic [5:0]  fc0;
    logic [3:0]  fc1;
    logic [4:0]  ffi0;
    logic [2:0]  ffi1;
    logic [31:0] ffg0, ffg1, cc0, cc1;

    dmem_result_checker_if #(.DW(32), .AW(32), .IW(5)) m0 ();
    dmem_result_checker_if #(.DW(32), .AW(32), .IW(3)) m1 ();

    dmem_result_checker u0 (
        .clk(clk), .reset(reset), .start(start0), .idata_mon(idata0), .mem(m0.master),
        .busy(busy0), .done(done0), .pass(pass0), .early_stop(es0), .fail_count(fc0),
        .first_fail_idx(ffi0), .first_fail_got(ffg0), .cycle_count(cc0)
    );

    dmem_result_checker #(
        .NWORDS(N1), .BASE_ADDR(B1), .RUN_CYCLES(RC1), .IDLE_STOP(1), .IDLE_LIMIT(LIM1)
    ) u1 (
        .clk(clk), .reset(reset), .start(start1), .idata_mon(idata1), .mem(m1.master),
        .busy(busy1), .done(done1), .pass(pass1), .early_stop(es1), .fail_count(fc1),
        .first_fail_idx(ffi1), .first_fail_got(ffg1), .cycle_count(cc1)
    );

    // Memory and expected-value sources
    logic [31:0] mem  [2][32];
    logic [31:0] expd [2][32];
    logic [31:0] expm [2][32];
    logic [31:0] idq  [1000];
    logic [31:0] rdq0 [$];
    logic [31:0] rdq1 [$];

    assign m0.exp_data = expd[0][m0.exp_idx];
    assign m0.exp_mask = expm[0][m0.exp_idx];
    assign m1.exp_data = expd[1][m1.exp_idx];
    assign m1.exp_mask = expm[1][m1.exp_idx];

    always @(posedge clk) begin
        if (m0.rd_en) begin
            m0.rd_data <= mem[0][5'((m0.rd_addr - B0) >> 2)];
            rdq0.push_back(m0.rd_addr);
        end
        if (m1.rd_en) begin
            m1.rd_data <= mem[1][5'((m1.rd_addr - B1) >> 2)];
            rdq1.push_back(m1.rd_addr);
        end
    end

    logic        d_busy[2], d_done[2], d_pass[2], d_es[2], d_rden[2];
    int          d_fc[2], d_ffi[2], d_eidx[2];
    logic [31:0] d_ffg[2], d_cc[2], d_addr[2];
    always_comb begin
        d_busy[0] = busy0;  d_busy[1] = busy1;
        d_done[0] = done0;  d_done[1] = done1;
        d_pass[0] = pass0;  d_pass[1] = pass1;
        d_es[0]   = es0;    d_es[1]   = es1;
        d_rden[0] = m0.rd_en; d_rden[1] = m1.rd_en;
        d_fc[0]   = int'(fc0);  d_fc[1]  = int'(fc1);
        d_ffi[0]  = int'(ffi0); d_ffi[1] = int'(ffi1);
        d_eidx[0] = int'(m0.exp_idx); d_eidx[1] = int'(m1.exp_idx);
        d_ffg[0]  = ffg0;   d_ffg[1]  = ffg1;
        d_cc[0]   = cc0;    d_cc[1]   = cc1;
        d_addr[0] = m0.rd_addr; d_addr[1] = m1.rd_addr;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, expv);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v; else start1 = v;
    endtask

    task automatic set_idata(input int d, input logic [31:0] v);
        if (d == 0) idata0 = v; else idata1 = v;
    endtask

    function automatic int nwords(input int d);
        return (d == 0) ? N0 : N1;
    endfunction

    task automatic init_mem(input int d);
        for (int i = 0; i < 32; i++) begin
            expd[d][i] = 32'h1234_5678 ^ (i * 32'h0101_0101);
            expm[d][i] = 32'hFFFF_FFFF;
            mem[d][i]  = expd[d][i];
        end
    endtask

    task automatic fill_idata(input int zero_at);
        for (int k = 0; k < 1000; k++)
            idq[k] = (zero_at >= 0 && k >= zero_at) ? 32'h0 : 32'h13 + k;
    endtask

    task automatic reset_checks(input int d, input string tag);
        check({tag, " busy"}, d_busy[d], 0);
        check({tag, " done"}, d_done[d], 0);
        check({tag, " pass"}, d_pass[d], 0);
        check({tag, " early_stop"}, d_es[d], 0);
        check({tag, " fail_count"}, d_fc[d], 0);
        check({tag, " first_fail_idx"}, d_ffi[d], 0);
        check({tag, " first_fail_got"}, d_ffg[d], 0);
        check({tag, " cycle_count"}, d_cc[d], 0);
        check({tag, " rd_en"}, d_rden[d], 0);
        check({tag, " rd_addr"}, d_addr[d], (d == 0) ? B0 : B1);
        check({tag, " exp_idx"}, d_eidx[d], 0);
    endtask

    // One full run; expected done edge counts the start-sampling edge as edge 1.
    task automatic run_and_check(input int d, input string name, input int pulse_at,
                                 input int e_cc, input logic e_es, input int e_fc,
                                 input int e_fidx, input logic [31:0] e_fgot);
        int nw = nwords(d);
        int n = 0;
        int done_n = -1;
        int bad = 0;
        logic [31:0] base = (d == 0) ? B0 : B1;
        logic [31:0] q [$];
        if (d == 0) rdq0.delete(); else rdq1.delete();
        set_start(d, 1'b1);
        @(posedge clk); #1;
        set_start(d, 1'b0);
        set_idata(d, idq[0]);
        check({name, " busy in RUN"}, d_busy[d], 1);
        while (done_n < 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            set_idata(d, (n < 1000) ? idq[n] : 32'hFFFF_FFFF);
            set_start(d, n == pulse_at);
            if (d_done[d]) done_n = n;
        end
        set_start(d, 1'b0);
        check({name, " latency"}, done_n + 1, e_cc + nw + 2);
        check({name, " cycle_count"}, d_cc[d], e_cc);
        check({name, " early_stop"}, d_es[d], e_es);
        check({name, " fail_count"}, d_fc[d], e_fc);
        check({name, " first_fail_idx"}, d_ffi[d], e_fidx);
        check({name, " first_fail_got"}, d_ffg[d], e_fgot);
        check({name, " pass"}, d_pass[d], (e_fc == 0) ? 1 : 0);
        check({name, " busy in DONE"}, d_busy[d], 0);
        q = (d == 0) ? rdq0 : rdq1;
        if (q.size() != nw) bad++;
        for (int i = 0; i < q.size() && i < nw; i++)
            if (q[i] !== base + i * 4) bad++;
        check({name, " read addr sequence"}, bad, 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, " done held"}, {d_done[d], d_fc[d][15:0]}, {1'b1, e_fc[15:0]});
    endtask

    typedef struct {
        int          d;
        string       name;
        int          zero_at;
        int          pulse_at;
        int          cw0;
        logic [31:0] cv0;
        int          cw1;
        logic [31:0] cv1;
        int          mw;
        int          e_cc;
        logic        e_es;
        int          e_fc;
        int          e_fidx;
        logic [31:0] e_fgot;
    } vec_t;

    vec_t vecs[10];

    // Reference model: RUN length from the fetch trace, then a word-by-word masked compare.
    task automatic random_run(input int d, input int idx);
        int nw = nwords(d);
        int rc = (d == 0) ? RC0 : RC1;
        int zs, zl;
        int m_cc, m_fc, m_fidx;
        logic m_es;
        logic [31:0] m_fgot;
        for (int i = 0; i < nw; i++) begin
            expd[d][i] = $urandom;
            expm[d][i] = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            mem[d][i]  = ($urandom_range(0, 3) == 0) ? expd[d][i] ^ $urandom : expd[d][i];
        end
        zs = $urandom_range(0, rc + 10);
        zl = $urandom_range(0, 30);
        for (int k = 0; k < 1000; k++) begin
            if (k >= zs && k < zs + zl) idq[k] = 32'h0;
            else if ($urandom_range(0, 4) == 0) idq[k] = 32'h0;
            else idq[k] = $urandom | 32'h1;
        end
        m_cc = rc;
        m_es = 1'b0;
        if (d == 1) begin
            for (int c = LIM1 - 1; c < rc && !m_es; c++) begin
                int zeros = 0;
                for (int j = c - LIM1 + 1; j <= c; j++) if (idq[j] == 0) zeros++;
                if (zeros == LIM1) begin
                    m_es = 1'b1;
                    m_cc = c + 1;
                end
            end
        end
        m_fc = 0; m_fidx = 0; m_fgot = 32'h0;
        for (int i = 0; i < nw; i++) begin
            if (((mem[d][i] ^ expd[d][i]) & expm[d][i]) != 0) begin
                if (m_fc == 0) begin
                    m_fidx = i;
                    m_fgot = mem[d][i];
                end
                m_fc++;
            end
        end
        run_and_check(d, $sformatf("rand%0d_d%0d", idx, d), -1, m_cc, m_es, m_fc, m_fidx, m_fgot);
    endtask

    initial begin
        int n;
        int rd_seen;
        vecs[0] = '{0, "default pass",   -1,   -1, -1, 32'h0, -1, 32'h0, -1, 1000, 1'b0, 0, 0, 32'h0};
        vecs[1] = '{0, "words 3 and 17", -1,   -1,  3, 32'hDEADBEEF, 17, 32'h0, -1, 1000, 1'b0, 2, 3, 32'hDEADBEEF};
        vecs[2] = '{0, "masked word 5",  -1,   -1, -1, 32'h0, -1, 32'h0,  5, 1000, 1'b0, 0, 0, 32'h0};
        vecs[3] = '{0, "start in RUN",   -1,  300, -1, 32'h0, -1, 32'h0, -1, 1000, 1'b0, 0, 0, 32'h0};
        vecs[4] = '{0, "start in SCAN",  -1, 1010, -1, 32'h0, -1, 32'h0, -1, 1000, 1'b0, 0, 0, 32'h0};
        vecs[5] = '{0, "idle disabled",   0,   -1, -1, 32'h0, -1, 32'h0, -1, 1000, 1'b0, 0, 0, 32'h0};
        vecs[6] = '{1, "idle at 40",     40,   -1, -1, 32'h0, -1, 32'h0, -1,   56, 1'b1, 0, 0, 32'h0};
        vecs[7] = '{1, "both exits",     84,   -1, -1, 32'h0, -1, 32'h0, -1,  100, 1'b1, 0, 0, 32'h0};
        vecs[8] = '{1, "idle too late",  85,   -1, -1, 32'h0, -1, 32'h0, -1,  100, 1'b0, 0, 0, 32'h0};
        vecs[9] = '{1, "edge words",      0,   -1,  0, 32'hFFFF0000, 7, 32'h1, -1, 16, 1'b1, 2, 0, 32'hFFFF0000};

        init_mem(0);
        init_mem(1);
        #1;
        reset_checks(0, "reset d0");
        reset_checks(1, "reset d1");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            init_mem(vecs[v].d);
            if (vecs[v].cw0 >= 0) mem[vecs[v].d][vecs[v].cw0] = vecs[v].cv0;
            if (vecs[v].cw1 >= 0) mem[vecs[v].d][vecs[v].cw1] = vecs[v].cv1;
            if (vecs[v].mw >= 0) begin
                expm[vecs[v].d][vecs[v].mw] = 32'h0000_FFFF;
                mem[vecs[v].d][vecs[v].mw]  = expd[vecs[v].d][vecs[v].mw] ^ 32'hABCD_0000;
            end
            fill_idata(vecs[v].zero_at);
            run_and_check(vecs[v].d, vecs[v].name, vecs[v].pulse_at, vecs[v].e_cc,
                          vecs[v].e_es, vecs[v].e_fc, vecs[v].e_fidx, vecs[v].e_fgot);
        end

        // Reset while scanning word 10, with a mismatch already recorded at word 3.
        init_mem(0);
        mem[0][3] = 32'hDEADBEEF;
        idata0 = 32'h55;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        while (!(d_rden[0] && d_addr[0] == B0 + 40) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("reached word 10", (n < 3000) ? 1 : 0, 1);
        check("fail_count before reset", d_fc[0], 1);
        reset = 1'b0;
        #1;
        reset_checks(0, "mid-scan reset");
        @(negedge clk);
        reset = 1'b1;
        rd_seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (d_rden[0] || d_rden[1]) rd_seen++;
        end
        check("no read after release", rd_seen, 0);
        check("idle after release", {d_busy[0], d_done[0]}, 2'b00);
        mem[0][3] = expd[0][3];
        fill_idata(-1);
        run_and_check(0, "clean after reset", -1, 1000, 1'b0, 0, 0, 32'h0);

        for (int r = 0; r < 2; r++) random_run(0, r);
        for (int r = 0; r < 25; r++) random_run(1, r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
